pc_adder: RTL and testbench

- N-bit two's-complement adder for the single-cycle RISC-V datapath.
- Forms next-PC values: PC + 4 and PC + immediate branch/jump targets.
- Sum and status flags are combinational, with zero latency, so the single-cycle path sees the result in the same cycle.
- A registered copy of sum and flags is provided for trace/debug and later pipelining.

---
 rtl/pc_adder_pkg.sv | 35 +++
 rtl/pc_adder_cla4_group.sv | 39 +++
 rtl/pc_adder.sv | 80 ++++++++
 tb/tb_pc_adder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pc_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_adder_pkg
// Description : Shared types, group width and flag helper for pc_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_adder_pkg;

    localparam int GROUP_W = 4;

    // Bit order matches flags_q: {carry, overflow, zero, negative}.
    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    function automatic flags_t calc_flags(
        input logic a_msb,
        input logic b_msb,
        input logic sum_msb,
        input logic carry,
        input logic sum_is_zero
    );
        flags_t f;
        f.carry    = carry;
        f.overflow = (a_msb == b_msb) && (sum_msb != a_msb);
        f.zero     = sum_is_zero;
        f.negative = sum_msb;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_adder_cla4_group.sv
`default_nettype none
// ============================================================================
// Module      : cla4_group
// Description : Four-bit carry-lookahead group with group generate/propagate.
// Revision    : 1.0 - initial release
// ============================================================================
module cla4_group
    import pc_adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               g,
    output logic               p
);

    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum = w_p ^ w_c;

    // Group terms exclude cin so the second level can resolve carries in parallel.
    assign g = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    assign p = &w_p;

endmodule
`default_nettype wire

// File: rtl/pc_adder.sv
`default_nettype none
// ============================================================================
// Module      : pc_adder
// Description : N-bit two-level CLA adder for next-PC with flags and trace regs.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_adder
    import pc_adder_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] address,
    input  logic [N-1:0] b,
    output logic [N-1:0] pc_new,
    output logic         carry_out,
    output logic         overflow,
    output logic         zero,
    output logic         negative,
    output logic [N-1:0] pc_q,
    output logic [3:0]   flags_q
);

    localparam int c_GROUPS = N / GROUP_W;

    logic [c_GROUPS-1:0] w_grp_g;
    logic [c_GROUPS-1:0] w_grp_p;
    logic [c_GROUPS-1:0] w_grp_cin;
    logic                w_cout;
    flags_t              w_flags;
    logic [N-1:0]        r_pc;
    flags_t              r_flags;

    generate
        for (genvar k = 0; k < c_GROUPS; k++) begin : g_grp
            cla4_group u_grp (
                .a   (address[k*GROUP_W +: GROUP_W]),
                .b   (b[k*GROUP_W +: GROUP_W]),
                .cin (w_grp_cin[k]),
                .sum (pc_new[k*GROUP_W +: GROUP_W]),
                .g   (w_grp_g[k]),
                .p   (w_grp_p[k])
            );
        end
    endgenerate

    // Second-level chain operates only on group G/P, never on group sums.
    always_comb begin
        logic c;
        c         = 1'b0;
        w_grp_cin = '0;
        for (int k = 0; k < c_GROUPS; k++) begin
            w_grp_cin[k] = c;
            c            = w_grp_g[k] | (w_grp_p[k] & c);
        end
        w_cout = c;
    end

    assign w_flags   = calc_flags(address[N-1], b[N-1], pc_new[N-1], w_cout, ~|pc_new);
    assign carry_out = w_flags.carry;
    assign overflow  = w_flags.overflow;
    assign zero      = w_flags.zero;
    assign negative  = w_flags.negative;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_flags <= '0;
        end else begin
            r_pc    <= pc_new;
            r_flags <= w_flags;
        end
    end

    assign pc_q    = r_pc;
    assign flags_q = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_pc_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_adder
// Description : Directed-vector and random equivalence bench for pc_adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_adder;

    localparam int N = 32;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_sum;
        logic [3:0]   exp_flags;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] address;
    logic [N-1:0] b;
    logic [N-1:0] pc_new;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic [N-1:0] pc_q;
    logic [3:0]   flags_q;

    int errors = 0;
    int checks = 0;

    pc_adder #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .b         (b),
        .pc_new    (pc_new),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .pc_q      (pc_q),
        .flags_q   (flags_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[11];

    initial begin
        logic [N:0]   ref_sum;
        logic [3:0]   ref_flags;
        logic         ref_ovf;

        vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0010};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0001};
        vecs[2]  = '{32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001};
        vecs[3]  = '{32'h0000_0020, 32'hFFFF_FFF0, 32'h0000_0010, 4'b1000};
        vecs[4]  = '{32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0000, 4'b1010};
        vecs[5]  = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 4'b1001};
        vecs[6]  = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101};
        vecs[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 4'b1100};
        vecs[8]  = '{32'h1234_5678, 32'h8765_4321, 32'h9999_9999, 4'b0001};
        vecs[9]  = '{32'h0FFF_FFFF, 32'h0000_0001, 32'h1000_0000, 4'b0000};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010};

        reset   = 1'b1;
        address = 32'hDEAD_BEEF;
        b       = 32'h0000_0004;

        // Registered path held in reset with non-zero inputs.
        tick();
        tick();
        check("reset_pc_q", pc_q, 0);
        check("reset_flags_q", flags_q, 0);
        check("comb_in_reset", pc_new, 32'hDEAD_BEF3);

        for (int i = 0; i < 11; i++) begin
            address = vecs[i].a;
            b       = vecs[i].b;
            #1;
            check($sformatf("vec%0d_sum", i), pc_new, vecs[i].exp_sum);
            check($sformatf("vec%0d_flags", i), {carry_out, overflow, zero, negative},
                  vecs[i].exp_flags);
        end

        for (int i = 0; i < 10000; i++) begin
            address = $urandom();
            b       = (i % 4 == 0) ? 32'h4 : $urandom();
            #1;
            ref_sum   = {1'b0, address} + {1'b0, b};
            ref_ovf   = (address[N-1] ~^ b[N-1]) & (ref_sum[N-1] ^ address[N-1]);
            ref_flags = {ref_sum[N], ref_ovf, ref_sum[N-1:0] == 0, ref_sum[N-1]};
            check("rand_sum", {carry_out, pc_new}, ref_sum);
            check("rand_flags", {carry_out, overflow, zero, negative}, ref_flags);
        end

        // Release reset and capture an overflowing sum.
        @(negedge clk);
        reset   = 1'b0;
        address = 32'h7FFF_FFFF;
        b       = 32'h0000_0001;
        tick();
        check("reg_pc_ovf", pc_q, 32'h8000_0000);
        check("reg_flags_ovf", flags_q, 4'b0101);

        @(negedge clk);
        address = 32'h0000_0010;
        b       = 32'hFFFF_FFF0;
        check("reg_hold_pc", pc_q, 32'h8000_0000);
        tick();
        check("reg_pc_zero", pc_q, 32'h0000_0000);
        check("reg_flags_zero", flags_q, 4'b1010);

        @(negedge clk);
        address = 32'h1234_5678;
        b       = 32'h8765_4321;
        tick();
        check("reg_pc_mix", pc_q, 32'h9999_9999);
        check("reg_flags_mix", flags_q, 4'b0001);

        // Mid-stream reset clears on that single edge.
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("midreset_pc", pc_q, 0);
        check("midreset_flags", flags_q, 0);
        check("midreset_comb", pc_new, 32'h9999_9999);

        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_reset_pc", pc_q, 32'h9999_9999);
        check("post_reset_flags", flags_q, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
